// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake. Latency 1 (shifts by n > 0: n+1, one bit per cycle).
// Backpressure: a result is held until taken; in_ready is low while it is held or a shift runs.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic             c_flag;
   logic [WIDTH-1:0] shreg;
   logic [SHW-1:0]   cnt;
   logic             shdir;

   logic             accept;
   logic             arith, is_sub, cin, start_shift;
   logic [WIDTH:0]   addend, sum;
   logic [WIDTH-1:0] ny, fv;
   logic             ncout, novf;
   logic [WIDTH-1:0] sh_next;
   logic             sh_out;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state == SHIFT);

   always_comb begin
      arith       = 1'b0;
      is_sub      = 1'b0;
      cin         = 1'b0;
      start_shift = 1'b0;
      addend      = {1'b0, b};
      ny          = '0;
      ncout       = 1'b0;
      novf        = 1'b0;
      case (sel)
         4'h0: arith = 1'b1;
         4'h1: begin arith = 1'b1; is_sub = 1'b1; end
         4'h2: ny = a & b;
         4'h3: ny = a | b;
         4'h4: ny = a ^ b;
         4'h5: ny = ~a;
         4'h6: begin arith = 1'b1; addend = (WIDTH+1)'(1); end
         4'h7: begin arith = 1'b1; is_sub = 1'b1; addend = (WIDTH+1)'(1); end
         4'h8, 4'h9: begin
            if (b[SHW-1:0] == '0) ny = a;
            else                  start_shift = 1'b1;
         end
         4'hA: begin arith = 1'b1; cin = c_flag; end
         4'hB: begin arith = 1'b1; is_sub = 1'b1; cin = c_flag; end
         4'hC: begin arith = 1'b1; is_sub = 1'b1; end
         4'hD: ny = b;
         default: ny = '0;
      endcase

      // Bit WIDTH of the extended result is the carry for adds and the borrow for subtracts.
      if (is_sub) sum = {1'b0, a} - addend - {{WIDTH{1'b0}}, cin};
      else        sum = {1'b0, a} + addend + {{WIDTH{1'b0}}, cin};

      if (arith) begin
         ny    = sum[WIDTH-1:0];
         ncout = sum[WIDTH];
         if (is_sub) novf = (a[MSB] != addend[MSB]) && (sum[MSB] != a[MSB]);
         else        novf = (a[MSB] == addend[MSB]) && (sum[MSB] != a[MSB]);
      end

      // CMP reports flags of the difference but passes A through.
      fv = ny;
      if (sel == 4'hC) ny = a;
   end

   assign sh_next = shdir ? (shreg >> 1) : (shreg << 1);
   assign sh_out  = shdir ? shreg[0] : shreg[MSB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         y         <= '0;
         cout      <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         c_flag    <= 1'b0;
         shreg     <= '0;
         cnt       <= '0;
         shdir     <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            if (start_shift) begin
               state <= SHIFT;
               shreg <= a;
               cnt   <= b[SHW-1:0];
               shdir <= sel[0];
            end else begin
               y         <= ny;
               cout      <= ncout;
               zero      <= (fv == '0);
               neg       <= fv[MSB];
               ovf       <= novf;
               c_flag    <= ncout;
               out_valid <= 1'b1;
            end
         end else if (state == SHIFT) begin
            shreg <= sh_next;
            cnt   <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
               state     <= IDLE;
               y         <= sh_next;
               cout      <= sh_out;
               zero      <= (sh_next == '0);
               neg       <= sh_next[MSB];
               ovf       <= 1'b0;
               c_flag    <= sh_out;
               out_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases plus random ops against an arithmetic reference model.
module tb_alu_pipe;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [7:0] a, b;
   logic [3:0] sel;
   logic       out_valid, out_ready;
   logic [7:0] y;
   logic       cout, zero, neg, ovf, busy;

   int tests = 0;
   int fails = 0;
   logic model_c = 1'b0;

   typedef struct packed {
      logic [7:0] y;
      logic       cout;
      logic       zero;
      logic       neg;
      logic       ovf;
   } res_t;

   alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: plain integer arithmetic on unsigned and signed views.
   function automatic res_t ref_op(input logic [3:0] s, input logic [7:0] x, input logic [7:0] z,
                                   input logic c);
      res_t r;
      int ux, uz, sx, sz, ar, sr, n, fvv;
      logic is_ar;
      ux = int'(x); uz = int'(z);
      sx = (ux > 127) ? ux - 256 : ux;
      sz = (uz > 127) ? uz - 256 : uz;
      n  = uz % 8;
      r = '0; is_ar = 1'b0; ar = 0; sr = 0; fvv = 0;
      case (s)
         4'h0: begin is_ar = 1; ar = ux + uz;         sr = sx + sz;         r.cout = (ar > 255); end
         4'h1: begin is_ar = 1; ar = ux - uz;         sr = sx - sz;         r.cout = (ux < uz); end
         4'h2: fvv = ux & uz;
         4'h3: fvv = ux | uz;
         4'h4: fvv = ux ^ uz;
         4'h5: fvv = 255 - ux;
         4'h6: begin is_ar = 1; ar = ux + 1;          sr = sx + 1;          r.cout = (ar > 255); end
         4'h7: begin is_ar = 1; ar = ux - 1;          sr = sx - 1;          r.cout = (ux < 1); end
         4'h8: begin fvv = (ux * (1 << n)) % 256; r.cout = (n > 0) ? ((ux >> (8 - n)) % 2 == 1) : 1'b0; end
         4'h9: begin fvv = ux >> n;               r.cout = (n > 0) ? ((ux >> (n - 1)) % 2 == 1) : 1'b0; end
         4'hA: begin is_ar = 1; ar = ux + uz + c;     sr = sx + sz + c;     r.cout = (ar > 255); end
         4'hB: begin is_ar = 1; ar = ux - uz - c;     sr = sx - sz - c;     r.cout = (ux < uz + c); end
         4'hC: begin is_ar = 1; ar = ux - uz;         sr = sx - sz;         r.cout = (ux < uz); end
         4'hD: fvv = uz;
         default: fvv = 0;
      endcase
      if (is_ar) begin
         fvv   = (ar + 512) % 256;
         r.ovf = (sr > 127) || (sr < -128);
      end
      r.zero = (fvv == 0);
      r.neg  = (fvv >= 128);
      r.y    = (s == 4'hC) ? x : 8'(fvv);
      return r;
   endfunction

   // Drives one op at a negedge, waits for the accept edge, returns cycles until out_valid (-1 on timeout).
   task automatic issue(input logic [3:0] s, input logic [7:0] aa, input logic [7:0] bb, output int lat);
      int g;
      g = 0;
      sel = s; a = aa; b = bb; in_valid = 1'b1;
      while (!in_ready && g < 50) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({out_valid, y, cout, zero, neg, ovf, busy} !== 14'b0) begin
         fails++;
         $display("FAIL reset_outputs: got ov=%b y=%h c=%b z=%b n=%b v=%b busy=%b, need all 0",
                  out_valid, y, cout, zero, neg, ovf, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
      model_c = 1'b0;
   endtask

   task automatic test_directed();
      int lat;
      logic [3:0] ds [6] = '{4'h0, 4'h0, 4'hA, 4'h1, 4'h0, 4'h9};
      logic [7:0] da [6] = '{8'hF0, 8'hFF, 8'h00, 8'h50, 8'h7F, 8'h81};
      logic [7:0] db [6] = '{8'h20, 8'h01, 8'h00, 8'h70, 8'h01, 8'h01};
      // expected {y, cout, zero, neg, ovf}
      res_t de [6] = '{{8'h10, 1'b1, 1'b0, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
                       {8'h01, 1'b0, 1'b0, 1'b0, 1'b0}, {8'hE0, 1'b1, 1'b0, 1'b1, 1'b0},
                       {8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, {8'h40, 1'b1, 1'b0, 1'b0, 1'b0}};
      int dl [6] = '{1, 1, 1, 1, 1, 2};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(ds[i], da[i], db[i], lat);
         tests++;
         if (lat != dl[i]) begin fails++; $display("FAIL directed_lat[%0d]: got %0d need %0d", i, lat, dl[i]); end
         tests++;
         if ({y, cout, zero, neg, ovf} !== de[i]) begin
            fails++;
            $display("FAIL directed_res[%0d]: got y=%h c=%b z=%b n=%b v=%b need %h", i, y, cout, zero, neg, ovf, de[i]);
         end
         model_c = de[i].cout;
      end
   endtask

   task automatic test_shift_busy();
      out_ready = 1'b1;
      @(negedge clk);
      sel = 4'h8; a = 8'h81; b = 8'h03; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if ({busy, in_ready, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL shl_busy[%0d]: got busy=%b in_ready=%b out_valid=%b need 1 0 0", k, busy, in_ready, out_valid);
         end
      end
      @(negedge clk);
      tests++;
      if ({busy, out_valid, y, cout} !== {1'b0, 1'b1, 8'h08, 1'b0}) begin
         fails++;
         $display("FAIL shl_result: got busy=%b ov=%b y=%h c=%b need 0 1 08 0", busy, out_valid, y, cout);
      end
      model_c = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      sel = 4'h0; a = 8'h30; b = 8'h05; in_valid = 1'b1;
      @(posedge clk); #1;
      sel = 4'h4; a = 8'hF0; b = 8'h0F;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if ({out_valid, in_ready, y, cout, zero, neg, ovf} !== {1'b1, 1'b0, 8'h35, 4'b0000}) begin
            fails++;
            $display("FAIL hold[%0d]: got ov=%b in_ready=%b y=%h need 1 0 35", k, out_valid, in_ready, y);
         end
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL take_in_ready: got %b need 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({out_valid, y, cout, zero, neg, ovf} !== {1'b1, 8'hFF, 4'b0010}) begin
         fails++;
         $display("FAIL take_next: got ov=%b y=%h c=%b z=%b n=%b v=%b need 1 ff 0 0 1 0", out_valid, y, cout, zero, neg, ovf);
      end
      model_c = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD};
      res_t e;
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         sel = ops[$urandom_range(0, 11)]; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
         e = ref_op(sel, a, b, model_c);
         #1;
         tests++;
         if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b need 1", i, in_ready); end
         @(negedge clk);
         tests++;
         if ({out_valid, y, cout, zero, neg, ovf} !== {1'b1, e}) begin
            fails++;
            $display("FAIL b2b_res[%0d]: got ov=%b y=%h c=%b z=%b n=%b v=%b need 1 %h", i, out_valid, y, cout, zero, neg, ovf, e);
         end
         model_c = e.cout;
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      res_t e;
      logic [3:0] s;
      logic [7:0] aa, bb;
      int lat, el;
      out_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         s = 4'($urandom); aa = 8'($urandom); bb = 8'($urandom);
         e = ref_op(s, aa, bb, model_c);
         el = ((s == 4'h8 || s == 4'h9) && (bb % 8 != 0)) ? int'(bb % 8) + 1 : 1;
         issue(s, aa, bb, lat);
         tests++;
         if (lat != el) begin fails++; $display("FAIL rand_lat[%0d] sel=%h: got %0d need %0d", i, s, lat, el); end
         tests++;
         if ({y, cout, zero, neg, ovf} !== e) begin
            fails++;
            $display("FAIL rand_res[%0d] sel=%h a=%h b=%h: got y=%h c=%b z=%b n=%b v=%b need %h",
                     i, s, aa, bb, y, cout, zero, neg, ovf, e);
         end
         model_c = e.cout;
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      int seen;
      out_ready = 1'b1;
      issue(4'h0, 8'hFF, 8'h01, lat);   // leaves C = 1 so the reset must clear it
      @(negedge clk);
      sel = 4'h8; a = 8'hFF; b = 8'h07; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, y, cout, zero, neg, ovf, busy} !== 14'b0) begin
         fails++;
         $display("FAIL abort_outputs: got ov=%b y=%h c=%b z=%b n=%b v=%b busy=%b need all 0",
                  out_valid, y, cout, zero, neg, ovf, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid || busy || !in_ready) seen++;
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL abort_quiet: got %0d bad cycles need 0", seen); end
      model_c = 1'b0;
      issue(4'hA, 8'h00, 8'h00, lat);
      tests++;
      if ({lat, y, cout} !== {32'sd1, 8'h00, 1'b0}) begin
         fails++;
         $display("FAIL abort_carry: got lat=%0d y=%h c=%b need 1 00 0", lat, y, cout);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_shift_busy();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
